// File: rtl/rf_operand_fetch.sv
// Operand fetch stage: hazard-checks decoded instructions against a per-register
// busy scoreboard, drives the register-file read ports and presents the operands
// to execute with a valid/ready handshake. Writebacks clear busy bits.
module rf_operand_fetch #(
  parameter int DEPTH = 8,
  parameter int ADDR  = 3,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADDR-1:0]  in_src1,
  input  logic             in_src1_en,
  input  logic [ADDR-1:0]  in_src2,
  input  logic             in_src2_en,
  input  logic [ADDR-1:0]  in_dst,
  input  logic             in_dst_en,
  output logic             rf_r1_en,
  output logic [ADDR-1:0]  rf_r1_addr,
  output logic             rf_r2_en,
  output logic [ADDR-1:0]  rf_r2_addr,
  input  logic [WIDTH-1:0] rf_r1_data,
  input  logic [WIDTH-1:0] rf_r2_data,
  input  logic             wb_valid,
  input  logic [ADDR-1:0]  wb_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_op1,
  output logic [WIDTH-1:0] out_op2,
  output logic [ADDR-1:0]  out_dst,
  output logic             out_dst_en,
  output logic [DEPTH-1:0] busy
);

  // IDLE: nothing held; RD: read data arriving on rf_rN_data; HOLD: operands latched.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] clr_vec;
  logic [ADDR-1:0]  dst_q;
  logic             dst_en_q, src1_en_q, src2_en_q;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic             hazard;
  logic             accept;

  // Decode the writeback port into one clear strobe per register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    clr_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      clr_vec[i] = wb_valid && (wb_addr == ADDR'(i));
    end
  end

  // RAW/WAW hazard: a used register is busy and is not being written back this cycle.
  always_comb begin
    hazard = (in_src1_en && busy_q[in_src1] && !clr_vec[in_src1])
          || (in_src2_en && busy_q[in_src2] && !clr_vec[in_src2])
          || (in_dst_en  && busy_q[in_dst]  && !clr_vec[in_dst]);
  end

  // A new instruction fits when the output slot is empty or is being drained.
  assign in_ready = !hazard && ((state_q == IDLE)
                            || (state_q == RD   && out_ready)
                            || (state_q == HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  // Register-file reads issue in the accept cycle; data returns next cycle.
  assign rf_r1_en   = accept && in_src1_en;
  assign rf_r1_addr = in_src1;
  assign rf_r2_en   = accept && in_src2_en;
  assign rf_r2_addr = in_src2;

  // Scoreboard next state: clear on writeback, then set on accept so set wins.
  always_comb begin
    busy_d = busy_q & ~clr_vec;
    if (accept && in_dst_en) begin
      busy_d[in_dst] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      busy_q <= busy_d;
    end
  end

  // Output FSM with instruction capture and operand latch for stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dst_q     <= '0;
      dst_en_q  <= 1'b0;
      src1_en_q <= 1'b0;
      src2_en_q <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
    end else begin
      // Accept is only possible when the current slot is empty or drains now.
      if (accept) begin
        dst_q     <= in_dst;
        dst_en_q  <= in_dst_en;
        src1_en_q <= in_src1_en;
        src2_en_q <= in_src2_en;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= RD;
        end
        RD: begin
          if (out_ready) begin
            state_q <= accept ? RD : IDLE;
          end else begin
            // Reg-file data is only valid for one cycle; keep it for the stall.
            state_q <= HOLD;
            op1_q   <= src1_en_q ? rf_r1_data : '0;
            op2_q   <= src2_en_q ? rf_r2_data : '0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= accept ? RD : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operands come straight from the reg file in RD and from the latch in HOLD.
  always_comb begin
    out_op1 = '0;
    out_op2 = '0;
    if (state_q == RD) begin
      out_op1 = src1_en_q ? rf_r1_data : '0;
      out_op2 = src2_en_q ? rf_r2_data : '0;
    end else if (state_q == HOLD) begin
      out_op1 = op1_q;
      out_op2 = op2_q;
    end
  end

  assign out_valid  = (state_q != IDLE);
  assign out_dst    = dst_q;
  assign out_dst_en = dst_en_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Bench for rf_operand_fetch: register-file model, scoreboard of expected
// operand bundles and one task per scenario.
module tb_rf_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_src1, in_src2, in_dst;
  logic        in_src1_en, in_src2_en, in_dst_en;
  logic        rf_r1_en, rf_r2_en;
  logic [2:0]  rf_r1_addr, rf_r2_addr;
  logic [15:0] rf_r1_data, rf_r2_data;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [15:0] out_op1, out_op2;
  logic [2:0]  out_dst;
  logic        out_dst_en;
  logic [7:0]  busy;

  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  dst;
    logic        dst_en;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  int   stall_cycles = 0;

  logic [15:0] regs [8] = '{16'h0A00, 16'h0A01, 16'h1111, 16'h2222,
                            16'h0A04, 16'h0A05, 16'h0A06, 16'h0A07};

  rf_operand_fetch #(.DEPTH(8), .ADDR(3), .WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src1_en (in_src1_en),
    .in_src2    (in_src2),
    .in_src2_en (in_src2_en),
    .in_dst     (in_dst),
    .in_dst_en  (in_dst_en),
    .rf_r1_en   (rf_r1_en),
    .rf_r1_addr (rf_r1_addr),
    .rf_r2_en   (rf_r2_en),
    .rf_r2_addr (rf_r2_addr),
    .rf_r1_data (rf_r1_data),
    .rf_r2_data (rf_r2_data),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_dst    (out_dst),
    .out_dst_en (out_dst_en),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: registered reads returning 0 when not enabled, writes on negedge.
  always @(posedge clk) begin
    rf_r1_data <= rf_r1_en ? regs[rf_r1_addr] : 16'h0;
    rf_r2_data <= rf_r2_en ? regs[rf_r2_addr] : 16'h0;
  end

  always @(negedge clk) begin
    if (wb_valid) regs[wb_addr] <= wb_data;
  end

  // Scoreboard: compare on output handshake, then push expectation on accept.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        n_pop++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_output got op1=%h op2=%h exp none", out_op1, out_op2);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_op1 !== e.op1 || out_op2 !== e.op2 || out_dst_en !== e.dst_en ||
              (e.dst_en && out_dst !== e.dst)) begin
            n_bad++;
            $display("FAIL sb_operands got op1=%h op2=%h dst=%0d/%b exp op1=%h op2=%h dst=%0d/%b",
                     out_op1, out_op2, out_dst, out_dst_en, e.op1, e.op2, e.dst, e.dst_en);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.op1    = in_src1_en ? regs[in_src1] : 16'h0;
        n.op2    = in_src2_en ? regs[in_src2] : 16'h0;
        n.dst    = in_dst;
        n.dst_en = in_dst_en;
        exp_q.push_back(n);
      end
    end
  end

  // Present one instruction and wait (bounded) until it is accepted.
  task automatic issue(input logic [2:0] s1, input logic e1, input logic [2:0] s2,
                       input logic e2, input logic [2:0] d, input logic de);
    int waited = 0;
    in_valid = 1'b1;
    in_src1 = s1; in_src1_en = e1;
    in_src2 = s2; in_src2_en = e2;
    in_dst  = d;  in_dst_en  = de;
    @(negedge clk); #1;
    while (!in_ready && waited < 20) begin
      waited++;
      stall_cycles++;
      @(negedge clk); #1;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout got in_ready=0 exp 1 within 20 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 8'h00 || out_op1 !== 16'h0 || out_op2 !== 16'h0 ||
        out_dst !== 3'd0 || out_dst_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got valid=%b busy=%h op1=%h op2=%h dst=%0d/%b exp all zero",
               out_valid, busy, out_op1, out_op2, out_dst, out_dst_en);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || rf_r1_en !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release got in_ready=%b rf_r1_en=%b out_valid=%b exp 1 0 0",
               in_ready, rf_r1_en, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    issue(3'd2, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 8'h10) begin
      n_bad++;
      $display("FAIL basic_issue got out_valid=%b busy=%h exp 1 10", out_valid, busy);
    end
    n_cmp++;
    if (out_op1 !== 16'h1111 || out_op2 !== 16'h2222) begin
      n_bad++;
      $display("FAIL basic_operands got op1=%h op2=%h exp 1111 2222", out_op1, out_op2);
    end
    wb_write(3'd4, 16'h4444);
    n_cmp++;
    if (busy !== 8'h00 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_clear got busy=%h out_valid=%b exp 00 0", busy, out_valid);
    end
  endtask

  task automatic test_raw_hazard();
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
    n_cmp++;
    if (busy !== 8'h20) begin
      n_bad++;
      $display("FAIL raw_busy_set got busy=%h exp 20", busy);
    end
    in_valid = 1'b1;
    in_src1 = 3'd5; in_src1_en = 1'b1;
    in_src2 = 3'd0; in_src2_en = 1'b0;
    in_dst  = 3'd0; in_dst_en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL raw_stall cycle %0d got in_ready=%b exp 0", i, in_ready);
      end
      @(posedge clk); #1;
    end
    wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
    @(negedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL raw_wb_accept got in_ready=%b exp 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wb_valid = 1'b0;
    n_cmp++;
    if (out_op1 !== 16'hBEEF || busy !== 8'h00) begin
      n_bad++;
      $display("FAIL raw_new_value got op1=%h busy=%h exp BEEF 00", out_op1, busy);
    end
  endtask

  task automatic test_hold();
    issue(3'd1, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_src1 = 3'd7; in_src1_en = 1'b1;
    in_src2 = 3'd0; in_src2_en = 1'b0;
    in_dst  = 3'd0; in_dst_en  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_op1 !== regs[1] || out_op2 !== regs[6] || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable cycle %0d got valid=%b op1=%h op2=%h in_ready=%b exp 1 %h %h 0",
                 i, out_valid, out_op1, out_op2, in_ready, regs[1], regs[6]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int pops_before;
    out_ready = 1'b1;
    stall_cycles = 0;
    pops_before = n_pop;
    for (int i = 0; i < 4; i++) begin
      issue(3'(i), 1'b1, 3'((i + 1) % 4), 1'b1, 3'(4 + i), 1'b1);
    end
    n_cmp++;
    if (stall_cycles != 0 || busy !== 8'hF0) begin
      n_bad++;
      $display("FAIL b2b_issue got stalls=%0d busy=%h exp 0 F0", stall_cycles, busy);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (n_pop - pops_before != 4) begin
      n_bad++;
      $display("FAIL b2b_outputs got %0d outputs exp 4", n_pop - pops_before);
    end
    @(posedge clk); #1;
    for (int i = 4; i < 8; i++) wb_write(3'(i), 16'h5000 + 16'(i));
    n_cmp++;
    if (busy !== 8'h00) begin
      n_bad++;
      $display("FAIL b2b_clear got busy=%h exp 00", busy);
    end
  endtask

  task automatic test_set_wins();
    issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1);
    in_valid = 1'b1;
    in_src1 = 3'd0; in_src1_en = 1'b0;
    in_src2 = 3'd0; in_src2_en = 1'b0;
    in_dst  = 3'd6; in_dst_en  = 1'b1;
    wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'h6666;
    @(negedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL setwin_accept got in_ready=%b exp 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wb_valid = 1'b0;
    n_cmp++;
    if (busy !== 8'h40) begin
      n_bad++;
      $display("FAIL setwin_busy got busy=%h exp 40", busy);
    end
    wb_write(3'd6, 16'h6667);
    wb_write(3'd2, 16'h1111);
    n_cmp++;
    if (busy !== 8'h00) begin
      n_bad++;
      $display("FAIL setwin_clear_nonbusy got busy=%h exp 00", busy);
    end
  endtask

  task automatic test_reset_in_hold();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(3'd0, 1'b0, 3'd0, 1'b0, 3'(i), 1'b1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 8'hFF || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rsthold_pre got busy=%h out_valid=%b exp FF 1", busy, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 8'h00 || out_op1 !== 16'h0 || out_dst_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rsthold_flush got valid=%b busy=%h op1=%h dst_en=%b exp 0 00 0000 0",
               out_valid, busy, out_op1, out_dst_en);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rsthold_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_src1 = '0; in_src1_en = 1'b0;
    in_src2 = '0; in_src2_en = 1'b0;
    in_dst  = '0; in_dst_en  = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_raw_hazard();
    test_hold();
    test_back_to_back();
    test_set_wins();
    test_reset_in_hold();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
